// File: rtl/rv_lsu_pkg.sv
// Shared types and decode helpers for the RV32I load/store unit.
package rv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

  // Undefined encodings (011, 110, 111) fall through to word.
  function automatic size_e size_dec(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (size_dec(f3))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Byte-lane steering: byte enables, store replication and load extension.
import rv_lsu_pkg::*;

module lsu_align (
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_fmt
);

  size_e       sz;
  logic [1:0]  o;
  logic [31:0] sh;

  always_comb begin
    sz        = size_dec(funct3);
    o         = off;
    be        = 4'b1111;
    wdata_rep = wdata;
    // Offsets are forced to natural alignment; misaligned accesses never reach here when trapping.
    case (sz)
      SZ_B: begin
        be        = 4'b0001 << o;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        o         = off & 2'b10;
        be        = 4'b0011 << o;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: o = 2'b00;
    endcase
    sh = raw >> {o, 3'b000};
    case (sz)
      SZ_B:    rdata_fmt = {{24{~funct3[2] & sh[7]}}, sh[7:0]};
      SZ_H:    rdata_fmt = {{16{~funct3[2] & sh[15]}}, sh[15:0]};
      default: rdata_fmt = raw;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit FSM between the RV32I core and a req/gnt/rvalid data RAM.
// Optional: define LSU_MISALIGN_TRAP_EN to skip memory and flag misaligned half/word accesses.
import rv_lsu_pkg::*;

module rv_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_e            state;
  logic              q_we;
  logic [ADDR_W-1:0] q_addr;
  logic [1:0]        q_off;
  logic [2:0]        q_f3;
  logic [31:0]       q_wdata;
  logic              q_mis;
  logic              issue;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       rdata_fmt;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  // Request is captured at acceptance so a misbehaving core cannot disturb an access in flight.
  lsu_align u_align (
    .off       (q_off),
    .funct3    (q_f3),
    .wdata     (q_wdata),
    .raw       (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_fmt (rdata_fmt)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      q_we    <= 1'b0;
      q_addr  <= '0;
      q_off   <= 2'b00;
      q_f3    <= 3'b000;
      q_wdata <= '0;
      q_mis   <= 1'b0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          q_we    <= req_we;
          q_addr  <= req_addr[ADDR_W+1:2];
          q_off   <= req_addr[1:0];
          q_f3    <= req_funct3;
          q_wdata <= req_wdata;
          if (TRAP_EN && misaligned(req_funct3, req_addr[1:0])) begin
            q_mis <= 1'b1;
            rdata <= '0;
            state <= DONE;
          end else begin
            q_mis <= 1'b0;
            state <= ISSUE;
          end
        end
        ISSUE: if (mem_gnt) state <= q_we ? DONE : WAIT;
        WAIT: if (mem_rvalid) begin
          rdata <= rdata_fmt;
          state <= DONE;
        end
        DONE: begin
          q_mis <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issue     = (state == ISSUE);
  assign stall     = req_valid & (state != DONE);
  assign done      = (state == DONE);
  assign misalign  = TRAP_EN & done & q_mis;
  assign mem_req   = issue;
  assign mem_we    = issue & q_we;
  assign mem_addr  = issue ? q_addr : '0;
  assign mem_be    = issue ? be : 4'b0000;
  assign mem_wdata = issue ? wdata_rep : 32'd0;

endmodule

// File: tb/tb_rv_lsu.sv
// Randomised self-checking bench for rv_lsu with an arithmetic byte-lane reference model.
module tb_rv_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        CLK, RSTn;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        stall, done, misalign;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int          vec, err;
  logic [31:0] last_rd;

  rv_lsu #(.ADDR_W(10)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .done(done), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One complete access; gd = extra cycles before gnt, rd = extra WAIT cycles before rvalid.
  task automatic access(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] raw, input int gd, input int rd);
    int n, o, oa, cyc, reqc, waitc, stalls, exp_stalls;
    bit gnted, gnt_now, seen, mis;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld, exp_rd, v, mask;
    n  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o  = int'(addr[1:0]);
    oa = o - (o % n);
    mis = TRAP && (o % n != 0);
    exp_addr = 10'((addr >> 2) % 1024);
    exp_be   = 4'(((1 << n) - 1) << oa);
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % n) +: 8];
    v    = raw >> (8 * oa);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = v & mask;
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
    exp_ld = v;
    exp_rd = mis ? 32'd0 : (we ? last_rd : exp_ld);
    exp_stalls = mis ? 1 : 1 + (gd + 1) + (we ? 0 : rd + 1);

    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    cyc = 0; reqc = 0; waitc = 0; stalls = 0; gnted = 0; seen = 0;
    while (!seen && cyc < 64) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; gnt_now = 0;
      #1;
      if (done) begin
        seen = 1;
        vec++;
        if ({rdata, misalign, stall, mem_req} !== {exp_rd, mis, 1'b0, 1'b0}) begin
          err++;
          $display("FAIL done_cycle addr=%h f3=%0d we=%0d: rdata=%h mis=%b stall=%b req=%b, want rdata=%h mis=%b stall=0 req=0",
                   addr, f3, we, rdata, misalign, stall, mem_req, exp_rd, mis);
        end
      end else begin
        if (stall) stalls++;
        if (mem_req) begin
          vec++;
          if (mis || {mem_we, mem_addr, mem_be, mem_wdata} !== {we, exp_addr, exp_be, exp_wd}) begin
            err++;
            $display("FAIL mem_issue addr=%h f3=%0d: we=%b a=%h be=%b wd=%h, want we=%b a=%h be=%b wd=%h mis=%b",
                     addr, f3, mem_we, mem_addr, mem_be, mem_wdata, we, exp_addr, exp_be, exp_wd, mis);
          end
          gnt_now    = (reqc == gd);
          mem_gnt    = gnt_now;
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata  = $urandom();
          reqc++;
        end else if (gnted) begin
          mem_rvalid = (waitc == rd);
          mem_rdata  = mem_rvalid ? raw : $urandom();
          waitc++;
        end else begin
          mem_gnt = 1'($urandom_range(0, 1));
        end
      end
      @(posedge CLK);
      if (gnt_now) gnted = 1;
      if (!seen) @(negedge CLK);
      cyc++;
    end
    vec++;
    if (!seen) begin
      err++;
      $display("FAIL timeout addr=%h f3=%0d we=%0d: no done within %0d cycles", addr, f3, we, cyc);
    end else if (stalls != exp_stalls) begin
      err++;
      $display("FAIL stall_cycles addr=%h f3=%0d we=%0d: got %0d, want %0d", addr, f3, we, stalls, exp_stalls);
    end
    last_rd = exp_rd;
    @(negedge CLK);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    vec++;
    if ({done, misalign, mem_req} !== 3'b000) begin
      err++;
      $display("FAIL single_done: done=%b mis=%b req=%b after completion, want 000", done, misalign, mem_req);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0;
    req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; last_rd = '0;
    repeat (2) @(negedge CLK);
    #1;
    vec++;
    if ({stall, done, misalign, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      err++;
      $display("FAIL reset_values: stall=%b done=%b mis=%b rdata=%h req=%b we=%b a=%h be=%b wd=%h, want all 0",
               stall, done, misalign, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic test_directed();
    access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, 0);  // SW
    access(1'b0, 32'h13, 3'b000, 32'h0, 32'h80FF0000, 0, 0);  // LB  -> FFFFFF80
    vec++;
    if (rdata !== 32'hFFFFFF80) begin
      err++; $display("FAIL lb_0x13: rdata=%h, want ffffff80", rdata);
    end
    access(1'b0, 32'h13, 3'b100, 32'h0, 32'h80FF0000, 0, 0);  // LBU -> 00000080
    vec++;
    if (rdata !== 32'h00000080) begin
      err++; $display("FAIL lbu_0x13: rdata=%h, want 00000080", rdata);
    end
    access(1'b1, 32'h06, 3'b001, 32'h00001234, 32'h0, 0, 0);  // SH
    access(1'b0, 32'h40, 3'b010, 32'h0, 32'h13579BDF, 3, 2);  // LW slow gnt/rvalid
    access(1'b0, 32'h02, 3'b010, 32'h0, 32'hA5A5C3C3, 0, 0);  // LW misaligned
    vec++;
    if (rdata !== (TRAP ? 32'h0 : 32'hA5A5C3C3)) begin
      err++; $display("FAIL lw_0x02: rdata=%h, trap=%0d", rdata, TRAP);
    end
    access(1'b0, 32'h05, 3'b001, 32'h0, 32'h0000F00D, 1, 1);  // LH odd offset
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++)
      access(1'($urandom_range(0, 1)), $urandom(), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
             $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_reset_mid();
    access(1'b0, 32'h80, 3'b010, 32'h0, 32'hCAFEF00D, 0, 0);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_funct3 = 3'b010;
    @(negedge CLK);
    mem_gnt = 1'b1;                      // ISSUE: grant now
    @(negedge CLK);
    mem_gnt = 1'b0; req_valid = 1'b0;    // now in WAIT
    RSTn = 1'b0;
    #1;
    vec++;
    if ({stall, done, misalign, rdata, mem_req, mem_be} !== '0) begin
      err++;
      $display("FAIL reset_mid: stall=%b done=%b mis=%b rdata=%h req=%b be=%b, want all 0",
               stall, done, misalign, rdata, mem_req, mem_be);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      #1;
      vec++;
      if ({done, mem_req, rdata} !== {1'b0, 1'b0, 32'h0}) begin
        err++;
        $display("FAIL late_rvalid cyc%0d: done=%b req=%b rdata=%h, want 0 0 00000000", k, done, mem_req, rdata);
      end
      @(negedge CLK);
      mem_rvalid = 1'b0;
    end
    last_rd = '0;
    access(1'b0, 32'h2C, 3'b001, 32'h0, 32'h8001_7FFF, 0, 1);
  endtask

  initial begin
    vec = 0; err = 0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
Load/store unit directly downstream of the single-cycle RV32I core's data-memory port. It receives the core's MemRead/MemWrite request (byte address, funct3, store data) and drives a word-addressed data RAM through a req/gnt/rvalid handshake. It generates byte enables, replicates store data, and sign- or zero-extends load data. It holds the core with a stall until the access completes.

Parameters:
ADDR_W, 10, word-address width of the data RAM (matches the existing 10-bit DMEM address)

Ports:
CLK  in  1  clock
RSTn  in  1  reset, asynchronous, active-low
req_valid  in  1  core access request (MemRead | MemWrite); held stable while stall=1
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address (ALU result)
req_funct3  in  3  instruction[14:12]: size and sign
req_wdata  in  32  store data (rs2)
stall  out  1  core must hold PC and instruction
rdata  out  32  formatted load result; valid when done=1
done  out  1  one-cycle completion pulse
misalign  out  1  one-cycle misaligned-access pulse, coincident with done
mem_req  out  1  RAM request
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
mem_be  out  4  byte enables
mem_wdata  out  32  replicated store data
mem_gnt  in  1  RAM accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  raw read word

Behaviour:
- Reset values: stall=0, done=0, misalign=0, rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; state=IDLE.
- stall = req_valid & (state != DONE), combinational.
- FSM states and transitions:
  - IDLE: if req_valid, go to ISSUE. If the misaligned trap is enabled and the access is misaligned, go to DONE instead.
  - ISSUE: mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata derived from the request and held stable until mem_gnt. On gnt, a store goes to DONE and a load goes to WAIT.
  - WAIT: mem_req=0. On mem_rvalid, register the formatted data into rdata and go to DONE.
  - DONE: done=1, stall=0, go to IDLE. rdata holds until the next load's capture.
- Minimum latency: store 2 stall cycles; load 3 stall cycles (gnt and rvalid each take at least 1 cycle).
- Byte enables by size, offset o = req_addr[1:0]:
  - byte: 4'b0001<<o
  - half: 4'b0011<<o
  - word: 4'b1111
- Store data replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- Load formatting: select byte/half by offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Undefined funct3 (011, 110, 111): treated as a word access.
- mem_rvalid or mem_gnt outside ISSUE/WAIT: ignored.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A late rvalid after reset is ignored.
- req_valid dropping mid-operation is a protocol violation; the FSM completes the access anyway.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a half at odd offset or a word with o≠0 skips memory (no mem_req) and goes IDLE→DONE. That DONE cycle has misalign=1, done=1, rdata=0; no register side effect is implied.
- Undefined: misalign tied 0; low address bits are forced to natural alignment (half: o&2'b10, word: 0) before byte-enable generation and load formatting.

Decomposition:
- Package rv_lsu_pkg:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - size-decode function
- Sub-module lsu_align (combinational): computes mem_be and mem_wdata from addr/funct3/wdata, and formatted rdata from addr/funct3/mem_rdata. rv_lsu holds only the FSM and registers.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF, gnt immediate → mem_addr=4, mem_be=1111, mem_wdata=0xDEADBEEF; stall high 2 cycles, then done pulse.
- LB addr 0x13, mem_rdata 0x80FF0000 → rdata=0xFFFFFF80. LBU at the same address → 0x00000080. Load stall is 3 cycles.
- SH addr 0x06, data 0x00001234 → mem_addr=1, mem_be=1100, mem_wdata=0x12341234.
- LW with mem_gnt delayed 3 cycles and rvalid delayed 2 → stall held throughout, mem_req/mem_addr stable until gnt, done exactly once.
- LW addr 0x02: with LSU_MISALIGN_TRAP_EN → no mem_req, misalign=done=1, rdata=0. Without it → mem_addr=0, mem_be=1111.
- RSTn asserted in WAIT, rvalid arrives the cycle after release → state IDLE, rdata=0, no done pulse.
